// File: rtl/bcd_time_pkg.sv
// Shared types and helpers for the BCD time adjuster.
//   bcd_digit_t  : one BCD digit
//   adj_state_e  : button-hold FSM states
//   digit_max()  : largest legal value of digit idx (even -> 9, odd -> 5)
package bcd_time_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [2:0] {
    IDLE,
    INC_HOLD,
    INC_RPT,
    DEC_HOLD,
    DEC_RPT
  } adj_state_e;

  function automatic int digit_max(input int idx);
    return (idx % 2 == 0) ? 9 : 5;
  endfunction

endpackage

// File: rtl/bcd_time_adjuster_if.sv
// Control/data bundle between the button/preset side and the time adjuster.
//   load, in_time, add, sub       : driven by the master (button/preset logic)
//   out_time, wrap, load_err, busy : driven by the slave (bcd_time_adjuster)
interface bcd_time_adjuster_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    load;
  logic [4*NUM_DIGITS-1:0] in_time;
  logic                    add;
  logic                    sub;
  logic [4*NUM_DIGITS-1:0] out_time;
  logic                    wrap;
  logic                    load_err;
  logic                    busy;

  modport master (
    output load, in_time, add, sub,
    input  out_time, wrap, load_err, busy
  );

  modport slave (
    input  load, in_time, add, sub,
    output out_time, wrap, load_err, busy
  );
endinterface

// File: rtl/bcd_digit_counter.sv
// One adjustable BCD digit counting 0..MAX.
//   inc/dec : a step up/down is in progress this cycle
//   cin/bin : carry/borrow arriving from the next-lower digit
//   load/d  : synchronous preset (d is already range-checked by the caller)
//   q       : current digit value
//   cout    : this digit wraps MAX->0 during an up step
//   bout    : this digit wraps 0->MAX during a down step
module bcd_digit_counter
  import bcd_time_pkg::*;
#(
  parameter int MAX = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       dec,
  input  logic       cin,
  input  logic       bin,
  input  logic       load,
  input  bcd_digit_t d,
  output bcd_digit_t q,
  output logic       cout,
  output logic       bout
);

  localparam bcd_digit_t MAX_D = 4'(MAX);

  bcd_digit_t q_q, q_d;

  assign q    = q_q;
  assign cout = inc & cin & (q_q == MAX_D);
  assign bout = dec & bin & (q_q == 4'd0);

  always_comb begin
    q_d = q_q;
    if (load)           q_d = d;
    else if (inc & cin) q_d = (q_q == MAX_D) ? 4'd0 : q_q + 4'd1;
    else if (dec & bin) q_d = (q_q == 4'd0) ? MAX_D : q_q - 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;
  end

endmodule

// File: rtl/bcd_time_adjuster.sv
// N-digit BCD time register with +1/-1 adjustment at digit ADJ_LSD, full
// carry/borrow ripple into the higher digits, and hold-to-repeat.
//   clk, rst_n : clock, async active-low reset
//   bus.load / bus.in_time : preset; out-of-range digits load as 0 and set load_err
//   bus.add / bus.sub      : debounced level buttons
//   bus.out_time           : registered time value
//   bus.wrap               : 1-cycle pulse when the top digit over/underflows
//   bus.load_err           : sticky bad-preset flag, cleared by a clean load
//   bus.busy               : a button hold is in progress
module bcd_time_adjuster
  import bcd_time_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int ADJ_LSD      = 2,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100
) (
  input logic              clk,
  input logic              rst_n,
  bcd_time_adjuster_if.slave bus
);

  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST = CNT_W'(REPEAT_RATE - 1);

  adj_state_e                      state_q, state_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic                            add_q, sub_q;
  logic                            wrap_q, wrap_d;
  logic                            err_q, err_d;
  logic                            busy_q, busy_d;
  logic                            step_up, step_dn;
  logic                            load_bad;
  logic [NUM_DIGITS-1:0][3:0]      load_dig;
  logic [NUM_DIGITS-1:0][3:0]      digits;
  logic [NUM_DIGITS:ADJ_LSD]       carry, borrow;

  // ---------------- button edges / FSM ----------------
  logic add_only, sub_only, add_rise, sub_rise, inc_side, is_hold, btn_ok, hit;

  assign add_only = bus.add & ~bus.sub;
  assign sub_only = bus.sub & ~bus.add;
  assign add_rise = bus.add & ~add_q;
  assign sub_rise = bus.sub & ~sub_q;
  assign inc_side = (state_q == INC_HOLD) || (state_q == INC_RPT);
  assign is_hold  = (state_q == INC_HOLD) || (state_q == DEC_HOLD);
  assign btn_ok   = inc_side ? add_only : sub_only;
  assign hit      = (cnt_q == (is_hold ? DLY_LAST : RATE_LAST));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step_up = 1'b0;
    step_dn = 1'b0;
    if (bus.load) begin
      // load wins; a still-held button has no new edge, so it must be re-pressed
      state_d = IDLE;
      cnt_d   = '0;
    end else if (state_q == IDLE) begin
      cnt_d = '0;
      if (add_only && add_rise) begin
        step_up = 1'b1;
        state_d = INC_HOLD;
      end else if (sub_only && sub_rise) begin
        step_dn = 1'b1;
        state_d = DEC_HOLD;
      end
    end else if (!btn_ok) begin
      // released, or the other button joined in
      state_d = IDLE;
      cnt_d   = '0;
    end else if (hit) begin
      step_up = inc_side;
      step_dn = ~inc_side;
      state_d = inc_side ? INC_RPT : DEC_RPT;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // ---------------- preset range check ----------------
  always_comb begin
    bcd_digit_t dig;
    dig      = '0;
    load_bad = 1'b0;
    load_dig = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      dig = bus.in_time[4*i +: 4];
      if (int'(dig) > digit_max(i)) begin
        dig      = '0;
        load_bad = 1'b1;
      end
      load_dig[i] = dig;
    end
  end

  assign wrap_d = (step_up & carry[NUM_DIGITS]) | (step_dn & borrow[NUM_DIGITS]);
  assign err_d  = bus.load ? load_bad : err_q;
  assign busy_d = (state_d != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      // buttons held through reset must not count as a fresh press
      add_q   <= 1'b1;
      sub_q   <= 1'b1;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      add_q   <= bus.add;
      sub_q   <= bus.sub;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  // ---------------- digit datapath ----------------
  assign carry[ADJ_LSD]  = 1'b1;
  assign borrow[ADJ_LSD] = 1'b1;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
    if (i >= ADJ_LSD) begin : g_adj
      bcd_digit_counter #(.MAX(digit_max(i))) u_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (step_up),
        .dec  (step_dn),
        .cin  (carry[i]),
        .bin  (borrow[i]),
        .load (bus.load),
        .d    (load_dig[i]),
        .q    (digits[i]),
        .cout (carry[i+1]),
        .bout (borrow[i+1])
      );
    end else begin : g_hold
      bcd_digit_t hold_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        hold_q <= '0;
        else if (bus.load) hold_q <= load_dig[i];
      end
      assign digits[i] = hold_q;
    end
  end

  assign bus.out_time = digits;
  assign bus.wrap     = wrap_q;
  assign bus.load_err = err_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_bcd_time_adjuster.sv
module tb_bcd_time_adjuster;

  localparam int ND = 4;
  localparam int RD = 8;
  localparam int RR = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  bcd_time_adjuster_if #(.NUM_DIGITS(ND)) bus ();

  bcd_time_adjuster #(
    .NUM_DIGITS(ND), .ADJ_LSD(2), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // advance n clock edges, leaving time #1 past the last edge
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_load(input logic [15:0] v);
    bus.load = 1'b1; bus.in_time = v;
    tick(1);
    bus.load = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.load = 1'b0; bus.in_time = '0; bus.add = 1'b0; bus.sub = 1'b0;
    tick(2);
    tests++; if (bus.out_time !== 16'h0000) begin fails++; $display("FAIL reset_out got %h want %h", bus.out_time, 16'h0000); end
    tests++; if (bus.wrap !== 1'b0) begin fails++; $display("FAIL reset_wrap got %b want 0", bus.wrap); end
    tests++; if (bus.load_err !== 1'b0) begin fails++; $display("FAIL reset_err got %b want 0", bus.load_err); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic test_wrap_up;
    do_load(16'h5907);
    tests++; if (bus.out_time !== 16'h5907) begin fails++; $display("FAIL up_load got %h want %h", bus.out_time, 16'h5907); end
    bus.add = 1'b1;
    tick(1);
    tests++; if (bus.out_time !== 16'h0007) begin fails++; $display("FAIL up_wrap_out got %h want %h", bus.out_time, 16'h0007); end
    tests++; if (bus.wrap !== 1'b1) begin fails++; $display("FAIL up_wrap_pulse got %b want 1", bus.wrap); end
    tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL up_busy got %b want 1", bus.busy); end
    bus.add = 1'b0;
    tick(1);
    tests++; if (bus.wrap !== 1'b0) begin fails++; $display("FAIL up_wrap_clear got %b want 0", bus.wrap); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL up_busy_clear got %b want 0", bus.busy); end
    tests++; if (bus.out_time !== 16'h0007) begin fails++; $display("FAIL up_release_out got %h want %h", bus.out_time, 16'h0007); end
  endtask

  task automatic test_wrap_down;
    do_load(16'h0030);
    bus.sub = 1'b1;
    tick(1);
    tests++; if (bus.out_time !== 16'h5930) begin fails++; $display("FAIL dn_wrap_out got %h want %h", bus.out_time, 16'h5930); end
    tests++; if (bus.wrap !== 1'b1) begin fails++; $display("FAIL dn_wrap_pulse got %b want 1", bus.wrap); end
    bus.sub = 1'b0;
    tick(1);
    tests++; if (bus.wrap !== 1'b0) begin fails++; $display("FAIL dn_wrap_clear got %b want 0", bus.wrap); end
    // borrow across the digit boundary without touching the top
    do_load(16'h1000);
    bus.sub = 1'b1;
    tick(1);
    tests++; if (bus.out_time !== 16'h0900) begin fails++; $display("FAIL dn_borrow got %h want %h", bus.out_time, 16'h0900); end
    tests++; if (bus.wrap !== 1'b0) begin fails++; $display("FAIL dn_nowrap got %b want 0", bus.wrap); end
    bus.sub = 1'b0;
    tick(1);
  endtask

  task automatic test_repeat;
    do_load(16'h0900);
    bus.add = 1'b1;
    tick(1);
    tests++; if (bus.out_time !== 16'h1000) begin fails++; $display("FAIL rpt_first got %h want %h", bus.out_time, 16'h1000); end
    tests++; if (bus.wrap !== 1'b0) begin fails++; $display("FAIL rpt_carry_nowrap got %b want 0", bus.wrap); end
    tick(RD - 1);
    tests++; if (bus.out_time !== 16'h1000) begin fails++; $display("FAIL rpt_before_delay got %h want %h", bus.out_time, 16'h1000); end
    tick(1);
    tests++; if (bus.out_time !== 16'h1100) begin fails++; $display("FAIL rpt_after_delay got %h want %h", bus.out_time, 16'h1100); end
    tick(RD + 3*RR - RD - 1);
    tests++; if (bus.out_time !== 16'h1300) begin fails++; $display("FAIL rpt_total got %h want %h", bus.out_time, 16'h1300); end
    tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL rpt_busy got %b want 1", bus.busy); end
    bus.add = 1'b0;
    tick(2);
    tests++; if (bus.out_time !== 16'h1300) begin fails++; $display("FAIL rpt_release got %h want %h", bus.out_time, 16'h1300); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL rpt_busy_clear got %b want 0", bus.busy); end
  endtask

  task automatic test_both;
    do_load(16'h1200);
    bus.add = 1'b1; bus.sub = 1'b1;
    tick(1);
    tests++; if (bus.out_time !== 16'h1200) begin fails++; $display("FAIL both_press got %h want %h", bus.out_time, 16'h1200); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL both_busy got %b want 0", bus.busy); end
    bus.sub = 1'b0;
    tick(RD + 2);
    tests++; if (bus.out_time !== 16'h1200) begin fails++; $display("FAIL both_sub_release got %h want %h", bus.out_time, 16'h1200); end
    bus.add = 1'b0;
    tick(1);
    bus.add = 1'b1;
    tick(1);
    tests++; if (bus.out_time !== 16'h1300) begin fails++; $display("FAIL both_repress got %h want %h", bus.out_time, 16'h1300); end
    bus.add = 1'b0;
    tick(1);
  endtask

  task automatic test_load_err;
    do_load(16'h7A00);
    tests++; if (bus.out_time !== 16'h0000) begin fails++; $display("FAIL err_top_out got %h want %h", bus.out_time, 16'h0000); end
    tests++; if (bus.load_err !== 1'b1) begin fails++; $display("FAIL err_top_flag got %b want 1", bus.load_err); end
    tick(3);
    tests++; if (bus.load_err !== 1'b1) begin fails++; $display("FAIL err_sticky got %b want 1", bus.load_err); end
    do_load(16'h1200);
    tests++; if (bus.load_err !== 1'b0) begin fails++; $display("FAIL err_clear got %b want 0", bus.load_err); end
    tests++; if (bus.out_time !== 16'h1200) begin fails++; $display("FAIL err_clean_out got %h want %h", bus.out_time, 16'h1200); end
    do_load(16'h005F);
    tests++; if (bus.out_time !== 16'h0050) begin fails++; $display("FAIL err_low_out got %h want %h", bus.out_time, 16'h0050); end
    tests++; if (bus.load_err !== 1'b1) begin fails++; $display("FAIL err_low_flag got %b want 1", bus.load_err); end
    do_load(16'h5959);
    tests++; if (bus.load_err !== 1'b0) begin fails++; $display("FAIL err_max_ok got %b want 0", bus.load_err); end
    tests++; if (bus.wrap !== 1'b0) begin fails++; $display("FAIL err_load_nowrap got %b want 0", bus.wrap); end
  endtask

  task automatic test_load_priority;
    bus.load = 1'b1; bus.in_time = 16'h0000; bus.add = 1'b1;
    tick(1);
    bus.load = 1'b0;
    tests++; if (bus.out_time !== 16'h0000) begin fails++; $display("FAIL prio_out got %h want %h", bus.out_time, 16'h0000); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL prio_busy got %b want 0", bus.busy); end
    tick(RD + 4);
    tests++; if (bus.out_time !== 16'h0000) begin fails++; $display("FAIL prio_held got %h want %h", bus.out_time, 16'h0000); end
    bus.add = 1'b0;
    tick(1);
    bus.add = 1'b1;
    tick(1);
    tests++; if (bus.out_time !== 16'h0100) begin fails++; $display("FAIL prio_repress got %h want %h", bus.out_time, 16'h0100); end
    bus.add = 1'b0;
    tick(1);
  endtask

  task automatic test_reset_mid;
    do_load(16'h0000);
    bus.add = 1'b1;
    tick(RD + 2);
    tests++; if (bus.out_time !== 16'h0200) begin fails++; $display("FAIL rst_pre got %h want %h", bus.out_time, 16'h0200); end
    rst_n = 1'b0;
    #1;
    tests++; if (bus.out_time !== 16'h0000) begin fails++; $display("FAIL rst_async_out got %h want %h", bus.out_time, 16'h0000); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL rst_async_busy got %b want 0", bus.busy); end
    tick(1);
    rst_n = 1'b1;
    tick(RD + 2*RR);
    tests++; if (bus.out_time !== 16'h0000) begin fails++; $display("FAIL rst_held_btn got %h want %h", bus.out_time, 16'h0000); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL rst_held_busy got %b want 0", bus.busy); end
    bus.add = 1'b0;
    tick(1);
    bus.add = 1'b1;
    tick(1);
    tests++; if (bus.out_time !== 16'h0100) begin fails++; $display("FAIL rst_fresh_edge got %h want %h", bus.out_time, 16'h0100); end
    bus.add = 1'b0;
    tick(1);
  endtask

  initial begin
    test_reset;
    test_wrap_up;
    test_wrap_down;
    test_repeat;
    test_both;
    test_load_err;
    test_load_priority;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
